// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receiver slice.
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

endpackage

// File: rtl/uart_bit_timer.sv
// Down-counter that strobes tick when it reaches zero, then reloads one bit period;
// load overrides the count so the first strobe can be offset (half-bit alignment).
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] load_value,
  output logic        tick
);

  localparam logic [15:0] PERIOD_M1 = 16'(CLKS_PER_BIT - 1);

  logic [15:0] cnt;

  assign tick = (cnt == 16'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= 16'd0;
    end else if (load) begin
      cnt <= load_value;
    end else if (tick) begin
      cnt <= PERIOD_M1;
    end else begin
      cnt <= cnt - 16'd1;
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: start detect, mid-bit re-check, LSB-first data sampling, stop check.
// Only a frame with a good stop bit updates data_out and pulses received_byte.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1,
  parameter int DATA_BITS    = uart_pkg::DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 bit_in,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 received_byte,
  output state_e               fsm_state
);

  localparam int HALF = (CLKS_PER_BIT - 1) / 2;
  localparam int CW   = $clog2(DATA_BITS);
  // With no half-bit offset the detection edge already is the start-bit sample,
  // so the timer must count a full period to reach data bit 0.
  localparam logic [15:0] FIRST_LOAD = (HALF == 0) ? 16'(CLKS_PER_BIT - 1) : 16'(HALF - 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_BITS - 1);

  state_e                 state, state_next;
  logic [CW-1:0]          bit_cnt, bit_cnt_next;
  logic [DATA_BITS-1:0]   shift_reg, shift_next;
  logic [DATA_BITS-1:0]   data_next;
  logic                   received_next;
  logic                   timer_load;
  logic                   tick;

  assign fsm_state = state;

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .load      (timer_load),
    .load_value(FIRST_LOAD),
    .tick      (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      bit_cnt       <= '0;
      shift_reg     <= '0;
      data_out      <= '0;
      received_byte <= 1'b0;
    end else begin
      state         <= state_next;
      bit_cnt       <= bit_cnt_next;
      shift_reg     <= shift_next;
      data_out      <= data_next;
      received_byte <= received_next;
    end
  end

  always_comb begin
    state_next    = state;
    bit_cnt_next  = bit_cnt;
    shift_next    = shift_reg;
    data_next     = data_out;
    received_next = 1'b0;
    timer_load    = (state == IDLE);
    unique case (state)
      IDLE: begin
        if (!bit_in) begin
          state_next   = (HALF == 0) ? DATA : START;
          bit_cnt_next = '0;
        end
      end
      START: begin
        if (tick) begin
          state_next   = bit_in ? IDLE : DATA;
          bit_cnt_next = '0;
        end
      end
      DATA: begin
        if (tick) begin
          shift_next   = {bit_in, shift_reg[DATA_BITS-1:1]};
          bit_cnt_next = bit_cnt + CW'(1);
          if (bit_cnt == LAST_BIT) state_next = STOP;
        end
      end
      STOP: begin
        if (tick) begin
          if (bit_in) begin
            data_next     = shift_reg;
            received_next = 1'b1;
          end
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver at 1 and 16 clocks per bit.
`timescale 1ns/1ps
module tb_uart_receiver;
  import uart_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #1 clk = ~clk;

  logic       line1, line16;
  logic [7:0] data1, data16;
  logic       rb1, rb16;
  state_e     st1, st16;

  uart_receiver #(.CLKS_PER_BIT(1)) dut1 (
    .clk(clk), .rst(rst), .bit_in(line1),
    .data_out(data1), .received_byte(rb1), .fsm_state(st1)
  );

  uart_receiver #(.CLKS_PER_BIT(16)) dut16 (
    .clk(clk), .rst(rst), .bit_in(line16),
    .data_out(data16), .received_byte(rb16), .fsm_state(st16)
  );

  int vectors = 0;
  int miscompares = 0;
  int pulses1 = 0;
  int pulses16 = 0;

  // a pulse held for N cycles is counted N times
  always @(posedge clk) begin
    #0.5;
    if (rb1 === 1'b1) pulses1++;
    if (rb16 === 1'b1) pulses16++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // driver tasks; all called at a falling edge, sel is the DUT's bit period
  task automatic set_line(input int sel, input logic b);
    if (sel == 16) line16 = b;
    else line1 = b;
  endtask

  task automatic drive_bit(input int sel, input logic b);
    set_line(sel, b);
    repeat (sel) @(negedge clk);
  endtask

  task automatic send_frame(input int sel, input logic [7:0] d, input logic stop);
    drive_bit(sel, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(sel, d[i]);
    drive_bit(sel, stop);
  endtask

  task automatic idle(input int sel, input int n);
    set_line(sel, 1'b1);
    repeat (n) @(negedge clk);
  endtask

  logic [7:0] mid_byte;

  initial begin
    rst    = 1'b1;
    line1  = 1'b1;
    line16 = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_data1", 32'(data1), 32'h00);
    check("rst_rb1", 32'(rb1), 32'h0);
    check("rst_state1", 32'(st1), 32'(IDLE));
    check("rst_data16", 32'(data16), 32'h00);
    check("rst_rb16", 32'(rb16), 32'h0);
    check("rst_state16", 32'(st16), 32'(IDLE));
    rst = 1'b0;
    idle(1, 4);
    check("idle_pulses1", 32'(pulses1), 32'd0);
    check("idle_pulses16", 32'(pulses16), 32'd0);

    // bits 1,0,1,0,1,1,0,0 LSB first
    send_frame(1, 8'h35, 1'b1);
    check("f35_rb_on_stop", 32'(rb1), 32'h1);
    check("f35_data", 32'(data1), 32'h35);
    check("f35_pulses", 32'(pulses1), 32'd1);

    // back-to-back, bits 0,1,1,1,0,0,1,1
    send_frame(1, 8'hCE, 1'b1);
    check("fce_rb_on_stop", 32'(rb1), 32'h1);
    check("fce_data", 32'(data1), 32'hCE);
    check("fce_pulses", 32'(pulses1), 32'd2);
    idle(1, 3);
    check("fce_rb_low", 32'(rb1), 32'h0);
    check("fce_hold", 32'(data1), 32'hCE);

    // framing error
    send_frame(1, 8'h5A, 1'b0);
    idle(1, 4);
    check("ferr_pulses", 32'(pulses1), 32'd2);
    check("ferr_data", 32'(data1), 32'hCE);
    check("ferr_state", 32'(st1), 32'(IDLE));
    send_frame(1, 8'h81, 1'b1);
    check("f81_data", 32'(data1), 32'h81);
    check("f81_pulses", 32'(pulses1), 32'd3);
    idle(1, 3);

    // reset during data bit 4
    mid_byte = 8'h7E;
    drive_bit(1, 1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1, mid_byte[i]);
    set_line(1, mid_byte[4]);
    rst = 1'b1;
    @(negedge clk);
    check("mrst_data", 32'(data1), 32'h00);
    check("mrst_rb", 32'(rb1), 32'h0);
    check("mrst_state", 32'(st1), 32'(IDLE));
    set_line(1, 1'b1);
    @(negedge clk);
    // start bit presented on the first edge after release
    rst = 1'b0;
    send_frame(1, 8'hC3, 1'b1);
    check("fc3_data", 32'(data1), 32'hC3);
    check("fc3_pulses", 32'(pulses1), 32'd4);

    // 16 clocks per bit: one-cycle glitch is a false start
    set_line(16, 1'b0);
    @(negedge clk);
    idle(16, 40);
    check("glitch_pulses16", 32'(pulses16), 32'd0);
    check("glitch_data16", 32'(data16), 32'h00);
    check("glitch_state16", 32'(st16), 32'(IDLE));
    send_frame(16, 8'hA5, 1'b1);
    idle(16, 4);
    check("fa5_data16", 32'(data16), 32'hA5);
    check("fa5_pulses16", 32'(pulses16), 32'd1);
    check("fa5_state16", 32'(st16), 32'(IDLE));
    check("quiet_pulses1", 32'(pulses1), 32'd4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
